// File: rtl/id_ex_reg_if.sv
// ----------------------------------------------------------------------------
// id_ex_reg_if
//   Bundles the signals between the decode stage, the ID/EX pipeline register
//   and the EX stage.
//
//   Control   : flush, hold, fwd_rs_en, fwd_rt_en
//   D side    : pc_d, instr_d, rs_data_d, rt_data_d, imm_d, alu_src_d, alu_op_d,
//               reg_write_d, mem_write_d, mem_to_reg_d, wa_d, tnew_d
//   Refresh   : fwd_rs_data, fwd_rt_data
//   E side    : pc_e, instr_e, rs_data_e, rt_data_e, imm_e, alu_op_e,
//               reg_write_e, mem_write_e, mem_to_reg_e, wa_e, alu_a_e, alu_b_e,
//               tnew_e, valid_e
//
//   master : the pipeline around the register (drives D side, observes E side)
//   slave  : the register itself
// ----------------------------------------------------------------------------
interface id_ex_reg_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 2
);
    // Pipeline control
    logic          flush;
    logic          hold;
    logic          fwd_rs_en;
    logic          fwd_rt_en;
    logic [DW-1:0] fwd_rs_data;
    logic [DW-1:0] fwd_rt_data;

    // Decode-stage fields
    logic [DW-1:0] pc_d;
    logic [DW-1:0] instr_d;
    logic [DW-1:0] rs_data_d;
    logic [DW-1:0] rt_data_d;
    logic [DW-1:0] imm_d;
    logic          alu_src_d;
    logic [1:0]    alu_op_d;
    logic          reg_write_d;
    logic          mem_write_d;
    logic          mem_to_reg_d;
    logic [AW-1:0] wa_d;
    logic [TW-1:0] tnew_d;

    // Execute-stage fields
    logic [DW-1:0] pc_e;
    logic [DW-1:0] instr_e;
    logic [DW-1:0] rs_data_e;
    logic [DW-1:0] rt_data_e;
    logic [DW-1:0] imm_e;
    logic [1:0]    alu_op_e;
    logic          reg_write_e;
    logic          mem_write_e;
    logic          mem_to_reg_e;
    logic [AW-1:0] wa_e;
    logic [DW-1:0] alu_a_e;
    logic [DW-1:0] alu_b_e;
    logic [TW-1:0] tnew_e;
    logic          valid_e;

    modport master (
        output flush, hold, fwd_rs_en, fwd_rt_en, fwd_rs_data, fwd_rt_data,
        output pc_d, instr_d, rs_data_d, rt_data_d, imm_d, alu_src_d, alu_op_d,
        output reg_write_d, mem_write_d, mem_to_reg_d, wa_d, tnew_d,
        input  pc_e, instr_e, rs_data_e, rt_data_e, imm_e, alu_op_e,
        input  reg_write_e, mem_write_e, mem_to_reg_e, wa_e,
        input  alu_a_e, alu_b_e, tnew_e, valid_e
    );

    modport slave (
        input  flush, hold, fwd_rs_en, fwd_rt_en, fwd_rs_data, fwd_rt_data,
        input  pc_d, instr_d, rs_data_d, rt_data_d, imm_d, alu_src_d, alu_op_d,
        input  reg_write_d, mem_write_d, mem_to_reg_d, wa_d, tnew_d,
        output pc_e, instr_e, rs_data_e, rt_data_e, imm_e, alu_op_e,
        output reg_write_e, mem_write_e, mem_to_reg_e, wa_e,
        output alu_a_e, alu_b_e, tnew_e, valid_e
    );
endinterface

// File: rtl/id_ex_reg.sv
// ----------------------------------------------------------------------------
// id_ex_reg
//   ID/EX pipeline register of the five-stage MIPS core. Captures decoded
//   operands and control from D and presents them to the EX-stage ALU one
//   cycle later.
//
//   Ports
//     clk   : rising-edge clock
//     reset : asynchronous, active-low reset (0 = reset, all state cleared)
//     bus   : id_ex_reg_if.slave (D-side inputs, E-side outputs, control)
//
//   Edge priority: flush > hold > load.
//     flush : load the all-zero bubble
//     hold  : keep everything, except rs/rt may be refreshed from forwarding
//     load  : capture D fields, mark valid, count Tnew down by one (saturating)
// ----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 2
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_reg_if.slave   bus
);

    logic [DW-1:0] pc_q,         pc_d;
    logic [DW-1:0] instr_q,      instr_d;
    logic [DW-1:0] rs_q,         rs_d;
    logic [DW-1:0] rt_q,         rt_d;
    logic [DW-1:0] imm_q,        imm_d;
    logic          alu_src_q,    alu_src_d;
    logic [1:0]    alu_op_q,     alu_op_d;
    logic          reg_write_q,  reg_write_d;
    logic          mem_write_q,  mem_write_d;
    logic          mem_to_reg_q, mem_to_reg_d;
    logic [AW-1:0] wa_q,         wa_d;
    logic [TW-1:0] tnew_q,       tnew_d;
    logic          valid_q,      valid_d;

    // Tnew counted from D; one stage later it is one cycle closer, floored at 0.
    logic [TW-1:0] tnew_dec;

    always_comb begin
        if (bus.tnew_d == '0) begin
            tnew_dec = '0;
        end else begin
            tnew_dec = bus.tnew_d - TW'(1);
        end
    end

    always_comb begin
        // Default: hold every field.
        pc_d         = pc_q;
        instr_d      = instr_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        imm_d        = imm_q;
        alu_src_d    = alu_src_q;
        alu_op_d     = alu_op_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        wa_d         = wa_q;
        tnew_d       = tnew_q;
        valid_d      = valid_q;

        if (bus.flush) begin
            // Bubble is the same all-zero state as reset: no architectural effect.
            pc_d         = '0;
            instr_d      = '0;
            rs_d         = '0;
            rt_d         = '0;
            imm_d        = '0;
            alu_src_d    = 1'b0;
            alu_op_d     = 2'b00;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            wa_d         = '0;
            tnew_d       = '0;
            valid_d      = 1'b0;
        end else if (bus.hold) begin
            // EX is stalled; a producer may have finished meanwhile, so let the
            // forwarding network patch the held operands.
            if (bus.fwd_rs_en) begin
                rs_d = bus.fwd_rs_data;
            end
            if (bus.fwd_rt_en) begin
                rt_d = bus.fwd_rt_data;
            end
        end else begin
            pc_d         = bus.pc_d;
            instr_d      = bus.instr_d;
            rs_d         = bus.rs_data_d;
            rt_d         = bus.rt_data_d;
            imm_d        = bus.imm_d;
            alu_src_d    = bus.alu_src_d;
            alu_op_d     = bus.alu_op_d;
            reg_write_d  = bus.reg_write_d;
            mem_write_d  = bus.mem_write_d;
            mem_to_reg_d = bus.mem_to_reg_d;
            wa_d         = bus.wa_d;
            tnew_d       = tnew_dec;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= '0;
            instr_q      <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= 2'b00;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            wa_q         <= '0;
            tnew_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            imm_q        <= imm_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            wa_q         <= wa_d;
            tnew_q       <= tnew_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.pc_e         = pc_q;
    assign bus.instr_e      = instr_q;
    assign bus.rs_data_e    = rs_q;
    assign bus.rt_data_e    = rt_q;
    assign bus.imm_e        = imm_q;
    assign bus.alu_op_e     = alu_op_q;
    assign bus.reg_write_e  = reg_write_q;
    assign bus.mem_write_e  = mem_write_q;
    assign bus.mem_to_reg_e = mem_to_reg_q;
    assign bus.wa_e         = wa_q;
    assign bus.tnew_e       = tnew_q;
    assign bus.valid_e      = valid_q;

    // ALU operands straight off the register outputs, no extra stage.
    assign bus.alu_a_e = rs_q;
    assign bus.alu_b_e = alu_src_q ? imm_q : rt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned TW = 2;

    logic clk;
    logic reset;

    int total;
    int bad;

    id_ex_reg_if #(.DW(DW), .AW(AW), .TW(TW)) bus ();

    id_ex_reg #(.DW(DW), .AW(AW), .TW(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one active edge, then sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".pc"},     bus.pc_e, 32'h0);
        check({tag, ".instr"},  bus.instr_e, 32'h0);
        check({tag, ".rs"},     bus.rs_data_e, 32'h0);
        check({tag, ".rt"},     bus.rt_data_e, 32'h0);
        check({tag, ".imm"},    bus.imm_e, 32'h0);
        check({tag, ".alu_a"},  bus.alu_a_e, 32'h0);
        check({tag, ".alu_b"},  bus.alu_b_e, 32'h0);
        check({tag, ".op"},     32'(bus.alu_op_e), 32'h0);
        check({tag, ".rw"},     32'(bus.reg_write_e), 32'h0);
        check({tag, ".mw"},     32'(bus.mem_write_e), 32'h0);
        check({tag, ".m2r"},    32'(bus.mem_to_reg_e), 32'h0);
        check({tag, ".wa"},     32'(bus.wa_e), 32'h0);
        check({tag, ".tnew"},   32'(bus.tnew_e), 32'h0);
        check({tag, ".valid"},  32'(bus.valid_e), 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // 1. Reset with every input nonzero.
        reset              = 1'b0;
        bus.flush          = 1'b0;
        bus.hold           = 1'b0;
        bus.fwd_rs_en      = 1'b1;
        bus.fwd_rt_en      = 1'b1;
        bus.fwd_rs_data    = 32'h4444_4444;
        bus.fwd_rt_data    = 32'h5555_5555;
        bus.pc_d           = 32'h0000_1004;
        bus.instr_d        = 32'h8C22_0004;
        bus.rs_data_d      = 32'h1111_1111;
        bus.rt_data_d      = 32'h2222_2222;
        bus.imm_d          = 32'h3333_3333;
        bus.alu_src_d      = 1'b1;
        bus.alu_op_d       = 2'b11;
        bus.reg_write_d    = 1'b1;
        bus.mem_write_d    = 1'b1;
        bus.mem_to_reg_d   = 1'b1;
        bus.wa_d           = 5'd17;
        bus.tnew_d         = 2'd3;
        #3;
        check_bubble("reset");
        reset = 1'b1;
        step();
        check("load0.pc",    bus.pc_e, 32'h0000_1004);
        check("load0.instr", bus.instr_e, 32'h8C22_0004);
        check("load0.rs",    bus.rs_data_e, 32'h1111_1111);
        check("load0.rt",    bus.rt_data_e, 32'h2222_2222);
        check("load0.imm",   bus.imm_e, 32'h3333_3333);
        check("load0.alu_a", bus.alu_a_e, 32'h1111_1111);
        check("load0.alu_b", bus.alu_b_e, 32'h3333_3333);
        check("load0.op",    32'(bus.alu_op_e), 32'h3);
        check("load0.rw",    32'(bus.reg_write_e), 32'h1);
        check("load0.mw",    32'(bus.mem_write_e), 32'h1);
        check("load0.m2r",   32'(bus.mem_to_reg_e), 32'h1);
        check("load0.wa",    32'(bus.wa_e), 32'd17);
        check("load0.tnew",  32'(bus.tnew_e), 32'd2);
        check("load0.valid", 32'(bus.valid_e), 32'h1);

        // 2. Plain loads, operand select and Tnew countdown.
        bus.fwd_rs_en    = 1'b0;
        bus.fwd_rt_en    = 1'b0;
        bus.rs_data_d    = 32'h5;
        bus.rt_data_d    = 32'h3;
        bus.imm_d        = 32'hFFFF_FFF0;
        bus.alu_src_d    = 1'b0;
        bus.alu_op_d     = 2'b01;
        bus.mem_write_d  = 1'b0;
        bus.tnew_d       = 2'd2;
        step();
        check("load1.alu_a", bus.alu_a_e, 32'h5);
        check("load1.alu_b", bus.alu_b_e, 32'h3);
        check("load1.op",    32'(bus.alu_op_e), 32'h1);
        check("load1.tnew",  32'(bus.tnew_e), 32'd1);
        bus.alu_src_d = 1'b1;
        step();
        check("load2.alu_b", bus.alu_b_e, 32'hFFFF_FFF0);
        check("load2.rt",    bus.rt_data_e, 32'h3);
        bus.tnew_d = 2'd0;
        step();
        check("load3.tnew0", 32'(bus.tnew_e), 32'd0);
        bus.tnew_d = 2'd1;
        step();
        check("load4.tnew1", 32'(bus.tnew_e), 32'd0);

        // 3. Hold for three edges with changing D inputs.
        bus.instr_d   = 32'h0043_0821;
        bus.rs_data_d = 32'h0000_0010;
        bus.rt_data_d = 32'h0000_A5A5;
        bus.alu_src_d = 1'b0;
        bus.tnew_d    = 2'd3;
        step();
        check("load5.instr", bus.instr_e, 32'h0043_0821);
        check("load5.tnew",  32'(bus.tnew_e), 32'd2);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.instr_d   = 32'hFFFF_0000 + 32'(i);
            bus.rs_data_d = 32'h0BAD_0000 + 32'(i);
            bus.tnew_d    = 2'(i);
            step();
            check("hold.instr", bus.instr_e, 32'h0043_0821);
            check("hold.valid", 32'(bus.valid_e), 32'h1);
            check("hold.tnew",  32'(bus.tnew_e), 32'd2);
            check("hold.rs",    bus.rs_data_e, 32'h0000_0010);
        end

        // 4. Forwarding refresh while held.
        bus.fwd_rs_en   = 1'b1;
        bus.fwd_rs_data = 32'hDEAD_BEEF;
        bus.fwd_rt_data = 32'h1234_5678;
        step();
        check("fwd.rs",    bus.rs_data_e, 32'hDEAD_BEEF);
        check("fwd.alu_a", bus.alu_a_e, 32'hDEAD_BEEF);
        check("fwd.rt",    bus.rt_data_e, 32'h0000_A5A5);
        check("fwd.instr", bus.instr_e, 32'h0043_0821);
        bus.fwd_rs_en = 1'b0;
        bus.fwd_rt_en = 1'b1;
        step();
        check("fwdrt.rt",    bus.rt_data_e, 32'h1234_5678);
        check("fwdrt.alu_b", bus.alu_b_e, 32'h1234_5678);
        check("fwdrt.rs",    bus.rs_data_e, 32'hDEAD_BEEF);
        bus.hold      = 1'b0;
        bus.fwd_rs_en = 1'b1;
        bus.fwd_rt_en = 1'b1;
        bus.rs_data_d = 32'h0000_0077;
        bus.rt_data_d = 32'h0000_0088;
        step();
        check("nohold.rs", bus.rs_data_e, 32'h0000_0077);
        check("nohold.rt", bus.rt_data_e, 32'h0000_0088);

        // 5. Flush beats hold and forwarding.
        bus.flush       = 1'b1;
        bus.hold        = 1'b1;
        bus.reg_write_d = 1'b1;
        bus.mem_write_d = 1'b1;
        bus.wa_d        = 5'd31;
        bus.tnew_d      = 2'd3;
        step();
        check_bubble("flush");

        // 6. Reset pulse between edges while holding a valid instruction.
        bus.flush     = 1'b0;
        bus.hold      = 1'b0;
        bus.fwd_rs_en = 1'b0;
        bus.fwd_rt_en = 1'b0;
        bus.alu_op_d  = 2'b10;
        step();
        check("pre.valid", 32'(bus.valid_e), 32'h1);
        check("pre.op",    32'(bus.alu_op_e), 32'h2);
        bus.hold = 1'b1;
        step();
        check("pre.hold.valid", 32'(bus.valid_e), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_bubble("midreset");
        #1;
        reset = 1'b1;
        step();
        check_bubble("heldbubble");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
